// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment scanner for a BCD digit vector.
// Frame-synchronous updates, ghosting guard, leading-zero blanking.
module bcd_display_scanner #(
    parameter int DIGIT_BITS          = 4,
    parameter int NUM_DIGITS          = 4,
    parameter int SCAN_DIV            = 100000,
    parameter int GUARD_CYCLES        = 1000,
    parameter int ACTIVE_LOW          = 1,
    parameter int BLANK_LEADING_ZEROS = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 data_in_ready,
    input  logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] data_in,
    output logic [6:0]                           seg,
    output logic                                 dp,
    output logic [NUM_DIGITS-1:0]                an,
    output logic                                 frame_done
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic POL = (ACTIVE_LOW != 0);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                                state;
    logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] pending;
    logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] display;
    logic                                  pending_valid;
    logic [TW-1:0]                         tick;
    logic [IW-1:0]                         idx;

    logic                  last_tick;
    logic                  boundary;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] blank;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    function automatic logic [6:0] decode(input logic [DIGIT_BITS-1:0] d);
        case (int'(d))
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            7:       return 7'h07;
            8:       return 7'h7F;
            9:       return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    always_comb begin
        last_tick = (tick == TW'(SCAN_DIV - 1));
        boundary  = (state == SCAN) && last_tick
                    && (idx == IW'(NUM_DIGITS - 1));
        // Walk down from the top digit; a digit is blanked while every digit
        // at or above it is zero.
        zero_run = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (display[i] == '0);
            blank[i] = (BLANK_LEADING_ZEROS != 0) && (i > 0) && zero_run;
        end
        seg_raw = 7'h00;
        an_raw  = '0;
        if (state == SCAN && !blank[idx]) begin
            seg_raw = decode(display[idx]);
            for (int i = 0; i < NUM_DIGITS; i++)
                an_raw[i] = (idx == IW'(i)) && (tick >= TW'(GUARD_CYCLES));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= '0;
            pending_valid <= 1'b0;
            display       <= '0;
            tick          <= '0;
            idx           <= '0;
            seg           <= {7{POL}};
            an            <= {NUM_DIGITS{POL}};
            dp            <= POL;
            frame_done    <= 1'b0;
        end else begin
            seg        <= seg_raw ^ {7{POL}};
            an         <= an_raw ^ {NUM_DIGITS{POL}};
            dp         <= POL;
            frame_done <= boundary;
            case (state)
                IDLE: begin
                    tick <= '0;
                    idx  <= '0;
                    if (data_in_ready) begin
                        display <= data_in;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (last_tick) begin
                        tick <= '0;
                        idx  <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                    // Display only changes at the frame boundary so a frame never tears.
                    if (boundary) begin
                        pending_valid <= 1'b0;
                        if (data_in_ready)
                            display <= data_in;
                        else if (pending_valid)
                            display <= pending;
                    end else if (data_in_ready) begin
                        pending       <= data_in;
                        pending_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: high-true and low-true instances against
// a slot/phase reference model, directed scenarios plus random strobes.
module tb_bcd_display_scanner;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int G  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [N-1:0][3:0] din;
    logic [6:0]        seg_h, seg_l;
    logic [N-1:0]      an_h, an_l;
    logic              dp_h, dp_l, fd_h, fd_l;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                               7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                               7'h40, 7'h40, 7'h40, 7'h40};

    // Reference model: elapsed cycles since scanning started
    bit running;
    int t;
    int disp [N];
    int pend [N];
    bit pv;
    logic [12:0] exp_v;

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .DIGIT_BITS(4), .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD_CYCLES(G),
        .ACTIVE_LOW(0), .BLANK_LEADING_ZEROS(1)
    ) dut_hi (
        .clk(clk), .rst(rst), .data_in_ready(rdy), .data_in(din),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
    );

    bcd_display_scanner #(
        .DIGIT_BITS(4), .NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD_CYCLES(G),
        .ACTIVE_LOW(1), .BLANK_LEADING_ZEROS(1)
    ) dut_lo (
        .clk(clk), .rst(rst), .data_in_ready(rdy), .data_in(din),
        .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l)
    );

    task automatic chk(input string tag, input logic [12:0] obs,
                       input logic [12:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [12:0] model_out();
        int slot, ph, msd;
        bit blk;
        logic [6:0] s;
        logic [N-1:0] a;
        if (!running) return 13'h0;
        slot = (t / SD) % N;
        ph   = t % SD;
        msd  = 0;
        for (int j = 0; j < N; j++) if (disp[j] != 0) msd = j;
        blk = (slot > msd);
        s = blk ? 7'h00 : glyph[disp[slot]];
        a = (!blk && ph >= G) ? N'(1) << slot : '0;
        return {s, a, 1'b0, (ph == SD - 1 && slot == N - 1)};
    endfunction

    function automatic bit at_boundary();
        return running && (t % SD == SD - 1) && ((t / SD) % N == N - 1);
    endfunction

    task automatic step(input bit r, input bit v, input logic [15:0] d);
        bit bnd;
        rst = r;
        rdy = v;
        din = d;
        @(posedge clk);
        exp_v = r ? 13'h0 : model_out();
        bnd = at_boundary();
        if (r) begin
            running = 0;
            t = 0;
            pv = 0;
            foreach (disp[j]) disp[j] = 0;
        end else if (!running) begin
            if (v) begin
                foreach (disp[j]) disp[j] = int'(d[j*4 +: 4]);
                running = 1;
                t = 0;
            end
        end else begin
            if (bnd) begin
                if (v) foreach (disp[j]) disp[j] = int'(d[j*4 +: 4]);
                else if (pv) disp = pend;
                pv = 0;
            end else if (v) begin
                foreach (pend[j]) pend[j] = int'(d[j*4 +: 4]);
                pv = 1;
            end
            t++;
        end
        #1;
        chk("out_hi", {seg_h, an_h, dp_h, fd_h}, exp_v);
        chk("out_lo", {seg_l, an_l, dp_l, fd_l}, exp_v ^ 13'h1FFE);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0);
    endtask

    initial begin
        int gap, cnt;
        bit found, seen1;
        logic [15:0] d;
        running = 0; t = 0; pv = 0;
        foreach (disp[j]) begin disp[j] = 0; pend[j] = 0; end
        rst = 1; rdy = 0; din = '0;

        step(1, 0, 16'h0);
        step(1, 0, 16'h0);
        idle(100);

        // Digits 1,2,3,4: measure frame period and enable duty
        step(0, 1, 16'h1234);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(0, 0, 16'h0);
            found = fd_h;
        end
        chk("fd_first", 13'(found), 13'd1);
        gap = 0; cnt = 0; found = 0; seen1 = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 0, 16'h0);
            gap++;
            if (an_h == 4'b0001) cnt++;
            if (an_h == 4'b0010 && !seen1) begin
                seen1 = 1;
                chk("slot1_seg", 13'(seg_h), 13'h4F);
            end
            found = fd_h;
        end
        chk("fd_period", 13'(gap), 13'd32);
        chk("an0_duty", 13'(cnt), 13'd6);

        step(0, 1, 16'h0007); idle(40);
        step(0, 1, 16'h0000); idle(40);

        // Mid-frame updates: newest pending value wins at the boundary
        step(0, 1, 16'h1234); idle(12);
        step(0, 1, 16'h9999); idle(5);
        step(0, 1, 16'h8888); idle(80);

        step(0, 1, 16'hA005); idle(40);

        // Strobe exactly on the boundary cycle
        for (int i = 0; i < 40 && !at_boundary(); i++) step(0, 0, 16'h0);
        step(0, 1, 16'h5678); idle(40);

        // Reset mid-scan then restart
        step(0, 1, 16'h4321); idle(20);
        step(1, 0, 16'h0); idle(10);
        step(0, 1, 16'h0305); idle(40);

        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < N; j++)
                d[j*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0
                                                          : 4'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 11) == 0, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed seven-segment driver that sits directly downstream of the BCD converter. It captures each completed BCD digit vector on its ready strobe and holds it until the next frame boundary, so updates never tear. It then scans the digits one at a time onto a shared segment bus and one-hot digit enables, with leading-zero blanking, inter-digit ghosting guard and an error glyph for non-decimal codes.

## Interface
- DIGIT_BITS, 4, bits per BCD digit
- NUM_DIGITS, 4, number of display digits (≥2)
- SCAN_DIV, 100000, clk cycles per digit slot (≥ GUARD_CYCLES+2)
- GUARD_CYCLES, 1000, cycles at start of each slot with all enables off
- ACTIVE_LOW, 1, 1 = seg/an/dp driven low-true; 0 = high-true
- BLANK_LEADING_ZEROS, 1, 1 = suppress zeros above most-significant nonzero digit

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- data_in_ready  in  1  one-cycle strobe, data_in valid this cycle
- data_in  in  [DIGIT_BITS-1:0] x [NUM_DIGITS-1:0]  BCD digits; index 0 = least significant
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point (always off in this block)
- an  out  NUM_DIGITS  one-hot digit enable; bit i drives digit i
- frame_done  out  1  one-cycle pulse at end of the last digit slot

## Operation
- Registers: pending[NUM_DIGITS], pending_valid, display[NUM_DIGITS], tick (0..SCAN_DIV-1), idx (0..NUM_DIGITS-1), state.
- States: IDLE (no data yet since reset), SCAN.
- IDLE: tick/idx held at 0; all outputs off. On data_in_ready: display <= data_in; → SCAN with tick=0, idx=0.
- SCAN: tick increments every cycle. At tick==SCAN_DIV-1: tick<=0, idx<=idx+1, wrapping NUM_DIGITS-1→0.
- Wrap cycle (tick==SCAN_DIV-1, idx==NUM_DIGITS-1) is the frame boundary: frame_done pulses; if pending_valid then display<=pending and pending_valid<=0.
- data_in_ready in SCAN on a non-boundary cycle: pending<=data_in, pending_valid<=1. Later strobes overwrite, so the newest value wins.
- data_in_ready on the boundary cycle: display<=data_in directly; pending_valid<=0.
- Enable: an[idx] active when tick ≥ GUARD_CYCLES and the digit is not blanked; all other bits off.
- Blanking: with BLANK_LEADING_ZEROS=1, digit i is blanked when display[j]==0 for all j≥i and i>0. Digit 0 is never blanked. A blanked digit has its enable off and seg off.
- Decode (active-high form, before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Codes 10-15 give 40 ("-"). Off = 00.
- Polarity: with ACTIVE_LOW=1, seg, an and dp are bitwise inverted at the output register. "Off" means all-ones.

## Timing
- All outputs are registered: value at cycle n+1 is a function of state/idx/tick/display at cycle n.
- Reset: rst sampled high → next cycle state=IDLE, pending_valid=0, display=0, tick=idx=0. seg, an and dp are off and frame_done=0 on that same cycle.
- Reset mid-scan follows identical behaviour. No partial slot completes.
- First display: strobe at cycle T in IDLE → SCAN at T+1. an[0] is first active at T+1+GUARD_CYCLES+1, unless digit 0 is blanked (it never is).
- Each slot is SCAN_DIV cycles. The enable is off for the first GUARD_CYCLES (+1 registered lag) of each slot, and seg changes only while all enables are off.
- Frame period = NUM_DIGITS·SCAN_DIV cycles. frame_done is high exactly 1 cycle per frame, one cycle after the boundary cycle.
- A pending update becomes visible starting at the first slot of the next frame. Maximum latency is one frame plus one slot.
- No backpressure: data_in_ready is always accepted. Upstream needs no handshake.

## Test plan
(NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2, ACTIVE_LOW=0, BLANK_LEADING_ZEROS=1)
- Reset then no strobe for 100 cycles → seg=00, an=0000, frame_done never asserts.
- Strobe digits{3..0}={1,2,3,4} → slots show an=0001/seg=66, then 0010/4F, 0100/5B, 1000/06. Each enable is high 6 of 8 cycles. frame_done pulses every 32 cycles.
- Strobe {0,0,0,7} → only an=0001 with seg=07 ever asserts. Strobe {0,0,0,0} → an=0001 with seg=3F only.
- Strobe {1,2,3,4}, then strobe {9,9,9,9} in the middle of slot 1 → the remaining slots show 3,2,1. The 9s (6F) appear from the next frame's slot 0. A third strobe before the boundary overrides the second.
- Strobe {0xA,0,0,5} → slot 3 seg=40; slots 1-2 seg=3F (not blanked, nonzero digit above them).
- rst asserted in slot 2 → next cycle all outputs off and state IDLE. A new strobe restarts at slot 0 with display = new data. With ACTIVE_LOW=1, the same sequence gives bitwise-inverted seg/an, and off = 7F/1111.
